// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider / SCL generator with stretch and edge strobes.
// Optional mid-phase strobes enabled by defining CLK_DIV_PHASE_EN.
module clk_div_prog #(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 415,
  parameter int MIN_DIV     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  input  logic             hold,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             mid_hi_stb,
  output logic             mid_lo_stb,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN_HI, RUN_LO, STRETCH} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt, div, pend, ld_val;
  logic             pend_v, tc, rise, apply;
  always_comb begin
    tc     = cnt == div;
    rise   = !hold && (state == STRETCH || (state == RUN_LO && tc));
    apply  = pend_v && (state == IDLE || rise);
    ld_val = div_val < CNT_W'(MIN_DIV) ? CNT_W'(MIN_DIV) : div_val;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      div      <= CNT_W'(DIV_DEFAULT);
      pend     <= '0;
      pend_v   <= 1'b0;
      clk_out  <= 1'b1;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      div_ack  <= 1'b0;
    end else begin
      rise_stb <= rise;
      fall_stb <= state == RUN_HI && en && tc;
      div_ack  <= div_load;
      pend_v   <= div_load | (pend_v & ~apply);
      if (div_load) pend <= ld_val;
      if (apply) div <= pend;
      if (rise) begin
        state   <= en ? RUN_HI : IDLE;
        cnt     <= '0;
        clk_out <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (en) state <= RUN_HI;
          end
          RUN_HI: begin
            if (!en) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (tc) begin
              state   <= RUN_LO;
              cnt     <= '0;
              clk_out <= 1'b0;
            end else cnt <= cnt + 1'b1;
          end
          RUN_LO: begin
            if (tc) state <= STRETCH;
            else cnt <= cnt + 1'b1;
          end
          STRETCH: cnt <= cnt;
        endcase
      end
    end
  end
  assign busy = state != IDLE;
`ifdef CLK_DIV_PHASE_EN
  assign mid_hi_stb = state == RUN_HI && cnt == (div >> 1);
  assign mid_lo_stb = state == RUN_LO && cnt == (div >> 1);
`else
  assign mid_hi_stb = 1'b0;
  assign mid_lo_stb = 1'b0;
`endif
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: self-checking bench for clk_div_prog, countdown model plus directed timing checks.
module tb_clk_div_prog;
  logic        clk = 1'b0;
  logic        rst, en, div_load, hold;
  logic [15:0] div_val;
  logic        div_ack, clk_out, rise_stb, fall_stb, mid_hi_stb, mid_lo_stb, busy;
  int          checks = 0, errors = 0, cyc = 0;
`ifdef CLK_DIV_PHASE_EN
  localparam bit PH_EN = 1'b1;
`else
  localparam bit PH_EN = 1'b0;
`endif
  clk_div_prog dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val), .div_load(div_load),
    .div_ack(div_ack), .hold(hold), .clk_out(clk_out), .rise_stb(rise_stb),
    .fall_stb(fall_stb), .mid_hi_stb(mid_hi_stb), .mid_lo_stb(mid_lo_stb), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef enum int {M_IDLE, M_HI, M_LO, M_ST} mph_t;
  mph_t ph = M_IDLE;
  int   md = 415, mp = 0, rem = 0;
  bit   pv, lvl = 1, er, ef, ea, mrise, chk_on;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", n, act, exp, cyc);
    end
  endtask
  // Model tracks cycles remaining in the current half rather than a count-up.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      ph = M_IDLE; md = 415; pv = 0; lvl = 1; er = 0; ef = 0; ea = 0; rem = 0; chk_on = 1;
    end else begin
      mrise = 0; er = 0; ef = 0; ea = div_load;
      case (ph)
        M_IDLE: begin
          if (pv) begin md = mp; pv = 0; end
          if (en) begin ph = M_HI; rem = md + 1; end
        end
        M_HI: if (!en) ph = M_IDLE;
              else if (rem == 1) begin ph = M_LO; rem = md + 1; lvl = 0; ef = 1; end
              else rem--;
        M_LO: if (rem > 1) rem--; else if (hold) ph = M_ST; else mrise = 1;
        M_ST: if (!hold) mrise = 1;
      endcase
      if (mrise) begin
        if (pv) begin md = mp; pv = 0; end
        lvl = 1; er = 1; ph = en ? M_HI : M_IDLE; rem = md + 1;
      end
      if (div_load) begin mp = div_val < 1 ? 1 : int'(div_val); pv = 1; end
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("clk_out", clk_out, lvl);
    chk("rise_stb", rise_stb, er);
    chk("fall_stb", fall_stb, ef);
    chk("div_ack", div_ack, ea);
    chk("busy", busy, ph != M_IDLE);
    chk("mid_hi_stb", mid_hi_stb, PH_EN && ph == M_HI && (md + 1 - rem) == (md >> 1));
    chk("mid_lo_stb", mid_lo_stb, PH_EN && ph == M_LO && (md + 1 - rem) == (md >> 1));
  end
  task automatic wait_sig(input int w, output int t);
    logic s;
    t = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      s = w == 0 ? rise_stb : w == 1 ? fall_stb : w == 2 ? mid_hi_stb : mid_lo_stb;
      if (s) begin t = cyc; break; end
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL wait_sig%0d: timeout got none expected strobe", w);
    end
  endtask
  task automatic load(input int v);
    div_load = 1; div_val = 16'(v);
    @(negedge clk);
    div_load = 0;
    chk("ack_lit", div_ack, 1);
  endtask
  initial begin
    int t0, t1, t2, t3, n;
    rst = 1; en = 0; hold = 0; div_load = 0; div_val = 0;
    repeat (2) @(negedge clk);
    div_load = 1; div_val = 16'd5;
    @(negedge clk);
    div_load = 0;
    chk("rst_ack", div_ack, 0);
    chk("rst_clk_out", clk_out, 1);
    chk("rst_busy", busy, 0);
    rst = 0;
    @(negedge clk);
    en = 1; t0 = cyc;
    wait_sig(1, t1); chk("first_fall", t1 - t0, 417);
    wait_sig(0, t2); chk("first_low", t2 - t1, 416);
    wait_sig(1, t3); chk("period_832", t3 - t1, 832);
    load(1);
    wait_sig(0, t1); wait_sig(1, t2); chk("div1_high", t2 - t1, 2);
    wait_sig(0, t3); chk("div1_low", t3 - t2, 2);
    load(0);
    wait_sig(0, t1); wait_sig(1, t2); chk("div0_high", t2 - t1, 2);
    wait_sig(0, t3); chk("div0_low", t3 - t2, 2);
    div_load = 1; div_val = 16'd3;
    @(negedge clk);
    chk("b2b_ack1", div_ack, 1);
    div_val = 16'd5;
    @(negedge clk);
    div_load = 0;
    chk("b2b_ack2", div_ack, 1);
    wait_sig(0, t1); wait_sig(1, t2); chk("div5_high", t2 - t1, 6);
    wait_sig(0, t3); chk("div5_low", t3 - t2, 6);
    load(3);
    wait_sig(0, t1); wait_sig(1, t2);
    hold = 1; n = 0; t3 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 12) hold = 0;
      if (rise_stb) begin n++; t3 = cyc; end
    end
    chk("stretch_rises", n, 1);
    chk("stretch_low", t3 - t2, 14);
    en = 0;
    wait_sig(0, t1); chk("en_off_low_done", t1 - t2, 22);
    n = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); n += fall_stb; end
    chk("idle_no_fall", n, 0);
    chk("idle_clk_out", clk_out, 1);
    en = 1;
    repeat (2) @(negedge clk);
    chk("hi_busy", busy, 1);
    en = 0; n = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); n += fall_stb; end
    chk("hi_abort_no_fall", n, 0);
    chk("hi_abort_busy", busy, 0);
    load(2);
    en = 1; t0 = cyc;
    wait_sig(1, t1); chk("idle_load_fall", t1 - t0, 4);
    div_load = 1; div_val = 16'd4;
    @(negedge clk);
    div_load = 0;
    @(negedge clk);
    div_load = 1; div_val = 16'd6;
    @(negedge clk);
    div_load = 0;
    chk("coincident_rise", rise_stb, 1);
    t1 = cyc;
    wait_sig(1, t2); chk("div4_high", t2 - t1, 5);
    wait_sig(0, t3); chk("div4_low", t3 - t2, 5);
    wait_sig(1, t1); chk("div6_high", t1 - t3, 7);
`ifdef CLK_DIV_PHASE_EN
    load(7);
    wait_sig(0, t1); wait_sig(2, t2); chk("mid_hi_pos", t2 - t1, 3);
    wait_sig(1, t3); chk("div7_high", t3 - t1, 8);
    wait_sig(3, t2); chk("mid_lo_pos", t2 - t3, 3);
`endif
    load(9);
    rst = 1;
    div_load = 1; div_val = 16'd2;
    @(negedge clk);
    div_load = 0;
    chk("midrst_ack", div_ack, 0);
    chk("midrst_clk_out", clk_out, 1);
    chk("midrst_busy", busy, 0);
    rst = 0; en = 1; t0 = cyc;
    wait_sig(1, t1); chk("post_rst_fall", t1 - t0, 417);
    en = 0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
